// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field bundles, packs each into a
// 32-bit instruction word and writes it to consecutive memory addresses
// starting at a base address captured when a program load begins.
module instr_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [3:0]       Cond,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rn,
    input  logic [3:0]       Rd,
    input  logic [23:0]      Imm,
    output logic             MemWrite,
    output logic [31:0]      Adr,
    output logic [31:0]      WriteData,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             error,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      adr_reg, adr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             last_reg, last_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0]      encoded;
    logic             illegal;

    // Pack the incoming fields; branches carry a 24-bit offset in place of registers
    always_comb begin
        if (Op == 2'b10) begin
            encoded = {Cond, Op, Funct[5:4], Imm};
        end else begin
            encoded = {Cond, Op, Funct, Rn, Rd, Imm[11:0]};
        end
    end

    // Flag reserved classes and data-processing opcodes other than ADD/SUB/AND/ORR
    always_comb begin
        illegal = 1'b0;
        if (Op == 2'b11) begin
            illegal = 1'b1;
        end else if (Op == 2'b00) begin
            case (Funct[4:1])
                4'b0100, 4'b0010, 4'b0000, 4'b1100: illegal = 1'b0;
                default:                            illegal = 1'b1;
            endcase
        end
    end

    // State and datapath registers; reset clears everything so no write can survive it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            adr_reg   <= '0;
            wdata_reg <= '0;
            last_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            wdata_reg <= wdata_next;
            last_reg  <= last_next;
            count_reg <= count_next;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        wdata_next = wdata_reg;
        last_next  = last_reg;
        count_next = count_reg;
        case (state_reg)
            S_IDLE, S_ERROR: begin
                // A new load restarts addressing and counting; leaving ERROR clears the flag
                if (start) begin
                    state_next = S_LOAD;
                    adr_next   = base_addr;
                    count_next = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (illegal) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_WRITE;
                        wdata_next = encoded;
                        last_next  = in_last;
                    end
                end
            end
            S_WRITE: begin
                // Address and count advance as the write completes; both wrap naturally
                adr_next   = adr_reg + 32'd4;
                count_next = count_reg + 1'b1;
                state_next = last_reg ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        in_ready  = (state_reg == S_LOAD);
        MemWrite  = (state_reg == S_WRITE);
        done      = (state_reg == S_DONE);
        error     = (state_reg == S_ERROR);
        Adr       = adr_reg;
        WriteData = wdata_reg;
        count     = count_reg;
        state     = state_reg;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: table of field bundles with hand-encoded words,
// plus sequences for ignored start, idle LOAD cycles and reset during a write.
module tb_instr_encoder;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [3:0]       Cond;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic [3:0]       Rn;
    logic [3:0]       Rd;
    logic [23:0]      Imm;
    logic             MemWrite;
    logic [31:0]      Adr;
    logic [31:0]      WriteData;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             error;
    logic [2:0]       state;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rn        (Rn),
        .Rd        (Rd),
        .Imm       (Imm),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .count     (count),
        .done      (done),
        .error     (error),
        .state     (state)
    );

    typedef struct {
        logic        first;   // issue start with base before this bundle
        logic [31:0] base;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [23:0] imm;
        logic        last;
        logic        legal;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [13];

    int checks = 0;
    int errors = 0;
    logic [31:0]      exp_adr;
    logic [CNT_W-1:0] exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input vec_t v);
        Cond    = v.cond;
        Op      = v.op;
        Funct   = v.funct;
        Rn      = v.rn;
        Rd      = v.rd;
        Imm     = v.imm;
        in_last = v.last;
    endtask

    initial begin
        // first  base           cond  op     funct      rn    rd    imm         last  legal wdata
        vecs[0]  = '{1'b1, 32'h0000_0100, 4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 24'h000005, 1'b1, 1'b1, 32'hE282_1005};
        vecs[1]  = '{1'b1, 32'h0000_0100, 4'hE, 2'b00, 6'b000101, 4'h3, 4'h3, 24'h000004, 1'b0, 1'b1, 32'hE053_3004};
        vecs[2]  = '{1'b0, 32'h0000_0000, 4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 24'h000002, 1'b1, 1'b1, 32'hEA00_0002};
        vecs[3]  = '{1'b1, 32'h0000_0200, 4'h0, 2'b00, 6'b011000, 4'h4, 4'h5, 24'h000ABC, 1'b0, 1'b1, 32'h0184_5ABC};
        vecs[4]  = '{1'b0, 32'h0000_0000, 4'hE, 2'b01, 6'b011001, 4'h1, 4'h2, 24'h123FFF, 1'b0, 1'b1, 32'hE591_2FFF};
        vecs[5]  = '{1'b0, 32'h0000_0000, 4'h1, 2'b00, 6'b000000, 4'hF, 4'h0, 24'hFFF000, 1'b0, 1'b1, 32'h100F_0000};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 2'b10, 6'b011111, 4'hF, 4'hF, 24'hABCDEF, 1'b1, 1'b1, 32'h09AB_CDEF};
        vecs[7]  = '{1'b1, 32'h0000_0300, 4'hE, 2'b00, 6'b011110, 4'h1, 4'h1, 24'h000001, 1'b1, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h0000_0400, 4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 24'h000000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0500, 4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 24'h000005, 1'b0, 1'b1, 32'hE282_1005};
        vecs[10] = '{1'b0, 32'h0000_0000, 4'hE, 2'b00, 6'b100010, 4'h1, 4'h1, 24'h000000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 24'h000005, 1'b0, 1'b1, 32'hE282_1005};
        vecs[12] = '{1'b0, 32'h0000_0000, 4'hE, 2'b00, 6'b000101, 4'h3, 4'h3, 24'h000004, 1'b1, 1'b1, 32'hE053_3004};

        reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        Cond = '0; Op = '0; Funct = '0; Rn = '0; Rd = '0; Imm = '0;
        exp_adr = '0; exp_count = '0;

        // Reset state
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_adr", Adr, 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_state", 32'(state), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].first) begin
                start = 1'b1;
                base_addr = vecs[i].base;
                tick();
                start = 1'b0;
                exp_adr = vecs[i].base;
                exp_count = '0;
                check($sformatf("v%0d_start_state", i), 32'(state), 32'd1);
                check($sformatf("v%0d_start_adr", i), Adr, exp_adr);
                check($sformatf("v%0d_start_count", i), 32'(count), 32'(exp_count));
                check($sformatf("v%0d_start_error", i), 32'(error), 32'd0);
                check($sformatf("v%0d_start_ready", i), 32'(in_ready), 32'd1);
            end else if (i % 2 == 0) begin
                // Idle LOAD cycle with a stray start: nothing may change
                in_valid = 1'b0;
                start = 1'b1;
                base_addr = 32'hDEAD_0000;
                tick();
                start = 1'b0;
                check($sformatf("v%0d_hold_state", i), 32'(state), 32'd1);
                check($sformatf("v%0d_hold_adr", i), Adr, exp_adr);
                check($sformatf("v%0d_hold_count", i), 32'(count), 32'(exp_count));
                check($sformatf("v%0d_hold_memwrite", i), 32'(MemWrite), 32'd0);
            end

            drive_fields(vecs[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;

            if (vecs[i].legal) begin
                check($sformatf("v%0d_wr_state", i), 32'(state), 32'd2);
                check($sformatf("v%0d_wr_memwrite", i), 32'(MemWrite), 32'd1);
                check($sformatf("v%0d_wr_ready", i), 32'(in_ready), 32'd0);
                check($sformatf("v%0d_wr_adr", i), Adr, exp_adr);
                check($sformatf("v%0d_wr_data", i), WriteData, vecs[i].wdata);
                exp_adr = exp_adr + 32'd4;
                exp_count = exp_count + 1'b1;
                tick();
                check($sformatf("v%0d_post_memwrite", i), 32'(MemWrite), 32'd0);
                check($sformatf("v%0d_post_count", i), 32'(count), 32'(exp_count));
                check($sformatf("v%0d_post_adr", i), Adr, exp_adr);
                if (vecs[i].last) begin
                    check($sformatf("v%0d_done_state", i), 32'(state), 32'd3);
                    check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd1);
                    tick();
                    check($sformatf("v%0d_idle_state", i), 32'(state), 32'd0);
                    check($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
                    check($sformatf("v%0d_idle_count", i), 32'(count), 32'(exp_count));
                end else begin
                    check($sformatf("v%0d_next_state", i), 32'(state), 32'd1);
                    check($sformatf("v%0d_next_ready", i), 32'(in_ready), 32'd1);
                end
            end else begin
                check($sformatf("v%0d_err_state", i), 32'(state), 32'd4);
                check($sformatf("v%0d_err_flag", i), 32'(error), 32'd1);
                check($sformatf("v%0d_err_memwrite", i), 32'(MemWrite), 32'd0);
                check($sformatf("v%0d_err_count", i), 32'(count), 32'(exp_count));
                tick();
                check($sformatf("v%0d_err_hold_state", i), 32'(state), 32'd4);
                check($sformatf("v%0d_err_hold_flag", i), 32'(error), 32'd1);
                check($sformatf("v%0d_err_hold_memwrite", i), 32'(MemWrite), 32'd0);
            end
        end

        // Reset asserted during a WRITE cycle
        start = 1'b1;
        base_addr = 32'h0000_0600;
        tick();
        start = 1'b0;
        drive_fields(vecs[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rstw_pre_memwrite", 32'(MemWrite), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_memwrite", 32'(MemWrite), 32'd0);
        check("rstw_state", 32'(state), 32'd0);
        check("rstw_adr", Adr, 32'd0);
        check("rstw_wdata", WriteData, 32'd0);
        check("rstw_count", 32'(count), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("rstw_after_state", 32'(state), 32'd0);
        check("rstw_after_ready", 32'(in_ready), 32'd0);
        check("rstw_after_count", 32'(count), 32'd0);
        check("rstw_after_memwrite", 32'(MemWrite), 32'd0);
        check("rstw_after_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the accepted-word counter.
REQ-002 Clock, reset and the port list below are fixed: one clock `clk`; reset `reset` is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a program load.
REQ-006 base_addr  in  32  first memory byte address; sampled on the accepted start.
REQ-007 in_valid  in  1  field bundle present.
REQ-008 in_ready  out  1  encoder can accept a bundle.
REQ-009 in_last  in  1  final instruction of the program.
REQ-010 Cond  in  4  condition field.
REQ-011 Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch.
REQ-012 Funct  in  6  function field.
REQ-013 Rn  in  4  first source register.
REQ-014 Rd  in  4  destination register.
REQ-015 Imm  in  24  operand; bits [11:0] are used for Op 00/01, bits [23:0] for Op 10.
REQ-016 MemWrite  out  1  memory write strobe.
REQ-017 Adr  out  32  write address.
REQ-018 WriteData  out  32  encoded instruction word.
REQ-019 count  out  CNT_W  number of words written.
REQ-020 done  out  1  one-cycle load-complete pulse.
REQ-021 error  out  1  illegal bundle detected; sticky.
REQ-022 state  out  3  current FSM state, for observation.

Function
REQ-023 States are IDLE=0, LOAD=1, WRITE=2, DONE=3, ERROR=4; the `state` output equals the current state.
REQ-024 Transitions:
- IDLE -> LOAD on start; this clears count and error and latches Adr<=base_addr.
- ERROR -> LOAD on start, with the same clearing and latching.
- start is ignored in LOAD, WRITE and DONE.
REQ-025 in_ready is 1 only in LOAD; a bundle transfers on the edge where in_valid & in_ready are both 1.
REQ-026 Encoding for Op 00/01: WriteData = {Cond, Op, Funct, Rn, Rd, Imm[11:0]}.
REQ-027 Encoding for Op 10: WriteData = {Cond, Op, Funct[5:4], Imm[23:0]}.
REQ-028 A bundle is illegal in either of these cases:
- Op==11;
- Op==00 with Funct[4:1] not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR}.
REQ-029 An illegal bundle that is transferred causes LOAD -> ERROR, with no write and count unchanged.
REQ-030 A legal bundle that is transferred causes LOAD -> WRITE; WriteData and in_last are registered on that edge.
REQ-031 WRITE lasts exactly one cycle, with MemWrite=1 and Adr, WriteData stable.
REQ-032 On leaving WRITE: Adr<=Adr+4 (wraps modulo 2^32) and count<=count+1 (wraps modulo 2^CNT_W).
REQ-033 From WRITE: if the latched in_last is 1, go to DONE, otherwise go to LOAD.
REQ-034 Latency: a bundle transferred at edge N produces MemWrite=1 in the cycle after edge N, and in_ready=0 in that cycle.
REQ-035 DONE lasts one cycle with done=1, then the FSM returns to IDLE.
REQ-036 In ERROR, error=1 and the FSM holds until start.
REQ-037 MemWrite is 0 in every state except WRITE.
REQ-038 When in_valid is 0 in LOAD, the FSM stays in LOAD with no output change.

Reset
REQ-039 While reset=0, the following hold asynchronously:
- state=IDLE;
- MemWrite=0, in_ready=0, done=0, error=0;
- Adr=0, WriteData=0, count=0.
REQ-040 Reset asserted mid-load (LOAD or WRITE) aborts the load; the pending write is not issued, and the block idles after release until the next start.

Verification
REQ-041 start with base_addr=0x100, then a bundle Cond=1110, Op=00, Funct=101000, Rn=2, Rd=1, Imm=0x005, in_last=1 -> the next cycle has MemWrite=1, Adr=0x100, WriteData=0xE2821005; done pulses the following cycle; count=1.
REQ-042 Two back-to-back bundles: SUBS (Cond=1110, Op=00, Funct=000101, Rn=3, Rd=3, Imm=0x004), then branch (Op=10, Funct=100000, Imm=0x000002, in_last=1) -> writes 0xE0533004 @0x100 and 0xEA000002 @0x104; count=2; in_ready=0 during each WRITE cycle.
REQ-043 Bundle with Op=00, Funct=011110 -> error=1 and state=ERROR, with no MemWrite; a later start clears error.
REQ-044 base_addr=0xFFFFFFFC and two legal bundles -> writes land at 0xFFFFFFFC, then 0x00000000.
REQ-045 reset driven low during WRITE -> MemWrite falls immediately; after release, state=IDLE, count=0, and in_ready=0 until start.
REQ-046 start pulsed in LOAD -> ignored; Adr and count remain unchanged.
